// File: rtl/flit_sink_monitor.sv
// flit_sink_monitor
//   Receive-side endpoint for a single-output flit stream. It is always ready,
//   so every ivalid cycle consumes a flit. It checks packet framing
//   (HEAD, DATA*, TAIL) and virtual-channel consistency, and it gathers
//   statistics while the meas_en window is open.
//
//   Optional feature macro: SINK_TOGGLE_CNT_EN
//     Defined   : toggle_cnt accumulates the Hamming distance between
//                 successive idata words, whether or not ivalid is set.
//     Undefined : there is no prev_data register, and toggle_cnt is tied to 0.
//
// Ports
//   clk, rst    clock and synchronous active-high reset
//   idata       flit; type = idata[FLIT_W-1 -: 3], payload = the remaining bits
//   ivalid      flit valid
//   ivch        virtual channel of the flit
//   meas_en     statistics window; counters move only while it is high
//   clr         synchronous clear of counters, last_len and err_flag
//   in_pkt      FSM is inside a packet (BODY)
//   pkt_cnt     packets closed by a legal TAIL
//   flit_cnt    valid flits accepted
//   busy_cnt    cycles with ivalid=1
//   toggle_cnt  accumulated idata Hamming distance
//   err_cnt     cycles containing at least one framing or protocol error
//   last_len    length of the most recently completed packet
//   err_flag    sticky error indicator
module flit_sink_monitor #(
  parameter int FLIT_W  = 35,
  parameter int VCH_W   = 2,
  parameter int CNT_W   = 32,
  parameter int MAX_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] idata,
  input  logic              ivalid,
  input  logic [VCH_W-1:0]  ivch,
  input  logic              meas_en,
  input  logic              clr,
  output logic              in_pkt,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  flit_cnt,
  output logic [CNT_W-1:0]  busy_cnt,
  output logic [CNT_W-1:0]  toggle_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [15:0]       last_len,
  output logic              err_flag
);

  localparam logic [2:0] TYPE_HEAD = 3'b001;
  localparam logic [2:0] TYPE_DATA = 3'b010;
  localparam logic [2:0] TYPE_TAIL = 3'b011;
  localparam logic [15:0] LEN_LIMIT = 16'(MAX_LEN);

  typedef enum logic {IDLE, BODY} state_t;

  state_t            state;
  logic [15:0]       len;
  logic [VCH_W-1:0]  cur_vch;
  logic              ovf_seen;   // the over-length error for this packet has already been reported

  logic [2:0]  flit_type;
  logic [15:0] len_inc;
  logic        start_pkt, grow, finish, len_ovf, err_now;

  assign flit_type = idata[FLIT_W-1 -: 3];
  assign len_inc   = (len == 16'hFFFF) ? len : len + 16'd1;
  assign in_pkt    = (state == BODY);

  // Decode the current flit into framing actions and an error indication.
  always_comb begin
    start_pkt = 1'b0;
    grow      = 1'b0;
    finish    = 1'b0;
    err_now   = 1'b0;
    if (ivalid) begin
      if (state == IDLE) begin
        if (flit_type == TYPE_HEAD) start_pkt = 1'b1;
        else                        err_now   = 1'b1;
      end else begin
        if (ivch != cur_vch) err_now = 1'b1;
        unique case (flit_type)
          TYPE_HEAD: begin err_now = 1'b1; start_pkt = 1'b1; end
          TYPE_DATA: grow = 1'b1;
          TYPE_TAIL: begin grow = 1'b1; finish = 1'b1; end
          default:   err_now = 1'b1;
        endcase
      end
    end
    // Flag an over-long packet only once, when len first exceeds MAX_LEN.
    len_ovf = grow && !ovf_seen && (len_inc > LEN_LIMIT);
    if (len_ovf) err_now = 1'b1;
  end

  // Framing FSM; it is unaffected by meas_en and clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      cur_vch  <= '0;
      ovf_seen <= 1'b0;
    end else if (start_pkt) begin
      state    <= BODY;
      len      <= 16'd1;
      cur_vch  <= ivch;
      ovf_seen <= 1'b0;
    end else if (grow) begin
      len <= len_inc;
      if (len_ovf) ovf_seen <= 1'b1;
      if (finish)  state    <= IDLE;
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Statistics. clr has priority over every update, and rst has priority over clr.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pkt_cnt  <= '0;
      flit_cnt <= '0;
      busy_cnt <= '0;
      err_cnt  <= '0;
      last_len <= '0;
      err_flag <= 1'b0;
    end else begin
      if (finish)  last_len <= len_inc;
      if (err_now) err_flag <= 1'b1;
      if (meas_en) begin
        if (finish)  pkt_cnt  <= sat_add(pkt_cnt, CNT_W'(1));
        if (ivalid)  flit_cnt <= sat_add(flit_cnt, CNT_W'(1));
        if (ivalid)  busy_cnt <= sat_add(busy_cnt, CNT_W'(1));
        if (err_now) err_cnt  <= sat_add(err_cnt, CNT_W'(1));
      end
    end
  end

`ifdef SINK_TOGGLE_CNT_EN
  logic [FLIT_W-1:0] prev_data;
  logic [FLIT_W-1:0] diff;
  logic [CNT_W-1:0]  pop;

  assign diff = idata ^ prev_data;

  always_comb begin
    pop = '0;
    for (int i = 0; i < FLIT_W; i++) pop = pop + CNT_W'(diff[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_data  <= '0;
      toggle_cnt <= '0;
    end else begin
      prev_data <= idata;
      if (clr)          toggle_cnt <= '0;
      else if (meas_en) toggle_cnt <= sat_add(toggle_cnt, pop);
    end
  end
`else
  // The payload bits are consumed only by the toggle counter.
  logic unused_payload;
  assign unused_payload = ^idata[FLIT_W-4:0];
  assign toggle_cnt     = '0;
`endif

endmodule

// File: tb/tb_flit_sink_monitor.sv
// Directed and randomized bench for flit_sink_monitor. Its reference model
// applies the framing and statistics rules one flit at a time, using integer
// arithmetic.
module tb_flit_sink_monitor;
  localparam int FLIT_W = 35, VCH_W = 2, CNT_W = 32, MAX_LEN = 64;
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, ivalid, meas_en, clr;
  logic [FLIT_W-1:0] idata;
  logic [VCH_W-1:0]  ivch;
  logic              in_pkt, err_flag;
  logic [CNT_W-1:0]  pkt_cnt, flit_cnt, busy_cnt, toggle_cnt, err_cnt;
  logic [15:0]       last_len;

  int vectors = 0, miscompares = 0;

  // Reference model state
  bit     m_in_pkt, m_ovf, m_flag;
  int     m_len, m_vch, m_last;
  longint m_pkt, m_flit, m_busy, m_tog, m_err;
  logic [FLIT_W-1:0] m_prev;

  flit_sink_monitor #(.FLIT_W(FLIT_W), .VCH_W(VCH_W), .CNT_W(CNT_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .meas_en(meas_en), .clr(clr), .in_pkt(in_pkt), .pkt_cnt(pkt_cnt),
    .flit_cnt(flit_cnt), .busy_cnt(busy_cnt), .toggle_cnt(toggle_cnt),
    .err_cnt(err_cnt), .last_len(last_len), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  function automatic longint sat(input longint v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    m_in_pkt = 0; m_ovf = 0; m_flag = 0; m_len = 0; m_vch = 0; m_last = 0;
    m_pkt = 0; m_flit = 0; m_busy = 0; m_tog = 0; m_err = 0; m_prev = '0;
  endtask

  task automatic model_step(input bit v, input logic [FLIT_W-1:0] d, input int vc,
                            input bit meas, input bit cl);
    int t;
    bit err, done;
    t = int'(d[FLIT_W-1 -: 3]);
    err = 0; done = 0;
    if (v) begin
      if (m_in_pkt && vc != m_vch) err = 1;
      if (t == 1) begin
        if (m_in_pkt) err = 1;
        m_in_pkt = 1; m_len = 1; m_vch = vc; m_ovf = 0;
      end else if (m_in_pkt && (t == 2 || t == 3)) begin
        m_len = (m_len >= 65535) ? 65535 : m_len + 1;
        if (m_len > MAX_LEN && !m_ovf) begin err = 1; m_ovf = 1; end
        if (t == 3) begin done = 1; m_in_pkt = 0; end
      end else begin
        err = 1;
      end
    end
    if (cl) begin
      m_pkt = 0; m_flit = 0; m_busy = 0; m_tog = 0; m_err = 0; m_last = 0; m_flag = 0;
    end else begin
      if (done) m_last = m_len;
      if (err)  m_flag = 1;
      if (meas) begin
        m_pkt  = sat(m_pkt  + longint'(done));
        m_flit = sat(m_flit + longint'(v));
        m_busy = sat(m_busy + longint'(v));
        m_err  = sat(m_err  + longint'(err));
`ifdef SINK_TOGGLE_CNT_EN
        m_tog  = sat(m_tog + longint'($countones(d ^ m_prev)));
`endif
      end
    end
    m_prev = d;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_pkt",     64'(in_pkt),     64'(m_in_pkt));
    chk("pkt_cnt",    64'(pkt_cnt),    64'(m_pkt));
    chk("flit_cnt",   64'(flit_cnt),   64'(m_flit));
    chk("busy_cnt",   64'(busy_cnt),   64'(m_busy));
    chk("toggle_cnt", 64'(toggle_cnt), 64'(m_tog));
    chk("err_cnt",    64'(err_cnt),    64'(m_err));
    chk("last_len",   64'(last_len),   64'(m_last));
    chk("err_flag",   64'(err_flag),   64'(m_flag));
  endtask

  task automatic cycd(input bit v, input logic [FLIT_W-1:0] d, input int vc,
                      input bit meas, input bit cl);
    ivalid = v; idata = d; ivch = VCH_W'(vc); meas_en = meas; clr = cl;
    @(posedge clk);
    model_step(v, d, vc, meas, cl);
    #1;
    check_all();
  endtask

  task automatic cyc(input bit v, input int typ, input int vc, input bit meas, input bit cl);
    logic [FLIT_W-1:0] d;
    d = {3'(typ), 32'($urandom)};
    cycd(v, d, vc, meas, cl);
  endtask

  task automatic do_reset();
    rst = 1; ivalid = 0; idata = '0; ivch = '0; meas_en = 0; clr = 0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 0;
    check_all();
  endtask

  task automatic packet(input int ndata, input int vc, input bit meas);
    cyc(1, 1, vc, meas, 0);
    for (int i = 0; i < ndata; i++) cyc(1, 2, vc, meas, 0);
    cyc(1, 3, vc, meas, 0);
  endtask

  initial begin
    int r, typ;
    logic [FLIT_W-1:0] ones;
    ones = '1;

    // Reset state
    do_reset();
    chk("rst_pkt", 64'(pkt_cnt), 0);
    chk("rst_flag", 64'(err_flag), 0);

    // A single legal packet
    meas_en = 1;
    packet(20, 0, 1);
    chk("legal_pkt", 64'(pkt_cnt), 1);
    chk("legal_flit", 64'(flit_cnt), 22);
    chk("legal_busy", 64'(busy_cnt), 22);
    chk("legal_len", 64'(last_len), 22);
    chk("legal_err", 64'(err_cnt), 0);
    chk("legal_inpkt", 64'(in_pkt), 0);

    // Ten packets separated by seven idle cycles
    do_reset();
    for (int p = 0; p < 10; p++) begin
      packet(20, 1, 1);
      for (int k = 0; k < 7; k++) cyc(0, 0, 0, 1, 0);
    end
    chk("traf_pkt", 64'(pkt_cnt), 10);
    chk("traf_flit", 64'(flit_cnt), 220);
    chk("traf_busy", 64'(busy_cnt), 220);
    chk("traf_err", 64'(err_cnt), 0);

    // Framing errors
    do_reset();
    cyc(1, 2, 0, 1, 0);
    chk("fr1_err", 64'(err_cnt), 1);
    chk("fr1_flag", 64'(err_flag), 1);
    cyc(1, 1, 0, 1, 0); cyc(1, 1, 0, 1, 0); cyc(1, 3, 0, 1, 0);
    chk("fr2_err", 64'(err_cnt), 2);
    chk("fr2_pkt", 64'(pkt_cnt), 1);
    chk("fr2_len", 64'(last_len), 2);
    cyc(1, 1, 0, 1, 0); cyc(1, 2, 1, 1, 0); cyc(1, 3, 0, 1, 0);
    chk("fr3_err", 64'(err_cnt), 3);
    chk("fr3_pkt", 64'(pkt_cnt), 2);
    chk("fr3_len", 64'(last_len), 3);

    // Closed window, then clr coinciding with a TAIL
    do_reset();
    packet(3, 2, 0);
    chk("win_pkt", 64'(pkt_cnt), 0);
    chk("win_flit", 64'(flit_cnt), 0);
    chk("win_len", 64'(last_len), 5);
    cyc(1, 1, 0, 1, 0); cyc(1, 2, 0, 1, 0); cyc(1, 3, 0, 1, 1);
    chk("clr_pkt", 64'(pkt_cnt), 0);
    chk("clr_len", 64'(last_len), 0);

    // Reset in the middle of a packet
    do_reset();
    cyc(1, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 2, 0, 1, 0);
    do_reset();
    cyc(1, 1, 0, 1, 0); cyc(1, 3, 0, 1, 0);
    chk("mid_pkt", 64'(pkt_cnt), 1);
    chk("mid_len", 64'(last_len), 2);
    chk("mid_err", 64'(err_cnt), 0);

    // A packet longer than MAX_LEN reports exactly one error
    do_reset();
    packet(70, 3, 1);
    chk("long_err", 64'(err_cnt), 1);
    chk("long_len", 64'(last_len), 72);
    chk("long_pkt", 64'(pkt_cnt), 1);

    // Toggle counting with alternating all-ones and all-zeros data
    do_reset();
    for (int i = 0; i < 4; i++) cycd(0, (i % 2 == 0) ? ones : '0, 0, 1, 0);
`ifdef SINK_TOGGLE_CNT_EN
    chk("toggle", 64'(toggle_cnt), 140);
`else
    chk("toggle", 64'(toggle_cnt), 0);
`endif

    // Randomized traffic checked against the model on every cycle
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 3)       typ = 1;
      else if (r < 12) typ = 2;
      else if (r < 16) typ = 3;
      else if (r < 17) typ = 0;
      else             typ = int'($urandom_range(4, 7));
      cyc($urandom_range(0, 3) != 0, typ,
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 0,
          $urandom_range(0, 9) != 0, $urandom_range(0, 63) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
